// File: rtl/circuito_entradas_juris.sv
// Jury input conditioning: per-bit synchronizer followed by a debouncer.
// Each bit of J is handled independently; {S1,S0} is the registered,
// debounced image of J.
module circuito_entradas_juris #(
    parameter int unsigned SYNC_STAGES     = 2,  // minimum 2
    parameter int unsigned DEBOUNCE_CYCLES = 4   // minimum 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] J,
    output logic       S1,
    output logic       S0
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q [SYNC_STAGES];
    logic [1:0]      sync;
    logic [1:0]      stab_q, stab_d;
    logic [CntW-1:0] cnt_q [2];
    logic [CntW-1:0] cnt_d [2];

    // Synchronizer chain, both bits side by side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= J;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Debounce next state: a new level is accepted once it has persisted for
    // DEBOUNCE_CYCLES consecutive edges; any return to the stable level restarts.
    always_comb begin
        stab_d = stab_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync[i] != stab_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stab_d[i] = sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_q   <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            stab_q   <= stab_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    assign S1 = stab_q[1];
    assign S0 = stab_q[0];

endmodule

// File: tb/tb_circuito_entradas_juris.sv
// Bench for circuito_entradas_juris: default instance plus a
// SYNC_STAGES=3 / DEBOUNCE_CYCLES=1 instance sharing the same stimulus.
module tb_circuito_entradas_juris;

    logic       clk;
    logic       rst_n;
    logic [1:0] J;
    logic       S1, S0;
    logic       S1s, S0s;

    int n_vec;
    int n_err;

    // Reference: every J value sampled at a rising edge since reset release.
    logic [1:0] hist[$];
    logic [1:0] m_a;
    logic [1:0] m_b;

    circuito_entradas_juris dut (
        .clk   (clk),
        .rst_n (rst_n),
        .J     (J),
        .S1    (S1),
        .S0    (S0)
    );

    circuito_entradas_juris #(
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (1)
    ) dut_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .J     (J),
        .S1    (S1s),
        .S0    (S0s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level seen at the synchronizer output just before edge m (1-based):
    // the J sampled s edges earlier, or 0 if that precedes reset release.
    function automatic logic [1:0] sync_before(input int m, input int s);
        int idx;
        idx = m - s;
        if (idx < 1) return 2'b00;
        return hist[idx-1];
    endfunction

    // A bit flips at edge n when the synchronized level differed from the
    // held level on each of the last d edges (n-d+1 .. n).
    function automatic logic [1:0] next_stab(input logic [1:0] cur, input int s, input int d);
        logic [1:0] res;
        logic [1:0] v;
        int n;
        bit all;
        n = hist.size();
        res = cur;
        for (int b = 0; b < 2; b++) begin
            all = 1'b1;
            for (int m = n - d + 1; m <= n; m++) begin
                v = sync_before(m, s);
                if (v[b] == cur[b]) all = 1'b0;
            end
            if (all) res[b] = ~cur[b];
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply J for one clock, advance the model, check both instances after the edge.
    task automatic step(input logic [1:0] j);
        J = j;
        @(posedge clk);
        if (rst_n) begin
            hist.push_back(J);
            m_a = next_stab(m_a, 2, 4);
            m_b = next_stab(m_b, 3, 1);
        end
        #1;
        check("dflt", {S1, S0}, m_a);
        check("sweep", {S1s, S0s}, m_b);
    endtask

    task automatic hold(input logic [1:0] j, input int cycles);
        for (int c = 0; c < cycles; c++) step(j);
    endtask

    // Assert reset away from a clock edge, check outputs clear at once,
    // keep it low across 'edges' clock edges, then release.
    task automatic pulse_reset(input int edges);
        rst_n = 1'b0;
        #1;
        hist.delete();
        m_a = 2'b00;
        m_b = 2'b00;
        check("rst_async", {S1, S0}, 2'b00);
        check("rst_async_sw", {S1s, S0s}, 2'b00);
        for (int c = 0; c < edges; c++) step(J);
        rst_n = 1'b1;
    endtask

    initial begin
        int seg;
        logic [1:0] jr;
        n_vec = 0;
        n_err = 0;
        m_a   = 2'b00;
        m_b   = 2'b00;
        J     = 2'b11;
        rst_n = 1'b0;
        #2;
        check("rst_init", {S1, S0}, 2'b00);
        hold(2'b11, 3);
        rst_n = 1'b1;

        // Hold J=3 after release: 11 appears on exactly the 6th edge.
        hold(2'b11, 5);
        check("lat_before", {S1, S0}, 2'b00);
        step(2'b11);
        check("lat_at6", {S1, S0}, 2'b11);

        // Reset with J high, then J=0 steady.
        pulse_reset(1);
        hold(2'b00, 10);
        check("steady0", {S1, S0}, 2'b00);

        // 0 -> 1: S0 rises on the 6th edge.
        hold(2'b01, 5);
        check("j1_5", {S1, S0}, 2'b00);
        step(2'b01);
        check("j1_6", {S1, S0}, 2'b01);
        hold(2'b01, 4);

        // 1 -> 2: both bits change together, no intermediate code.
        hold(2'b10, 5);
        check("j2_5", {S1, S0}, 2'b01);
        step(2'b10);
        check("j2_6", {S1, S0}, 2'b10);
        hold(2'b10, 4);

        // Glitch rejection: 3-cycle pulse ignored, 5-cycle pulse accepted.
        hold(2'b00, 10);
        hold(2'b11, 3);
        hold(2'b00, 10);
        check("glitch3", {S1, S0}, 2'b00);
        hold(2'b11, 5);
        hold(2'b00, 2);
        check("pulse5_hi", {S1, S0}, 2'b11);
        hold(2'b00, 8);
        check("pulse5_lo", {S1, S0}, 2'b00);

        // Reset mid-count: S1 rises only 6 edges after release.
        hold(2'b10, 3);
        pulse_reset(1);
        hold(2'b10, 5);
        check("midrst_5", {S1, S0}, 2'b00);
        step(2'b10);
        check("midrst_6", {S1, S0}, 2'b10);

        // Random segments with random hold lengths and occasional resets.
        for (seg = 0; seg < 300; seg++) begin
            jr = 2'($urandom_range(3, 0));
            hold(jr, int'($urandom_range(7, 1)));
            if ($urandom_range(39, 0) == 0) pulse_reset(int'($urandom_range(2, 0)));
        end
        hold(2'b00, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
